branch_redirect: RTL

BRANCH_REDIRECT -- requirements
Module: branch_redirect

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_redirect_target_gen.sv | 22 ++
 rtl/branch_redirect.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch redirect block: FSM encoding,
// comparator opcodes and RV32 control-flow opcodes.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_e;

  localparam logic [2:0] CMP_EQ          = 3'd0;
  localparam logic [2:0] CMP_NEQ         = 3'd1;
  localparam logic [2:0] CMP_UNSIGNED_LT = 3'd2;
  localparam logic [2:0] CMP_SIGNED_LT   = 3'd3;
  localparam logic [2:0] CMP_UNSIGNED_GE = 3'd4;
  localparam logic [2:0] CMP_SIGNED_GE   = 3'd5;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/branch_redirect_target_gen.sv
// Combinational redirect target: JALR uses rs1 base with bit 0 cleared,
// everything else is PC-relative; flags word-misaligned targets.
module target_gen (
  input  logic        is_jalr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] base;
  logic [31:0] sum;

  always_comb begin
    base       = is_jalr_i ? rs1_i : pc_i;
    sum        = base + imm_i;
    target_o   = is_jalr_i ? {sum[31:1], 1'b0} : sum;
    misalign_o = |target_o[1:0];
  end

endmodule

// File: rtl/branch_redirect.sv
// EX-stage redirect controller: IDLE -> REDIRECT (hold until IF accepts) ->
// FLUSH bubbles. Define BRANCH_STAT_EN to add branch/taken statistics counters.
module branch_redirect
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 is_branch_i,
  input  logic                 is_jal_i,
  input  logic                 is_jalr_i,
  input  logic                 branch_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          imm_i,
  input  logic [31:0]          rs1_i,
  input  logic                 fetch_ready_i,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 flush_o,
  output logic                 stall_o,
  output logic [31:0]          link_o,
`ifdef BRANCH_STAT_EN
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] taken_cnt_o,
`endif
  output logic                 misalign_o
);

  br_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target;
  logic        tgt_misalign;
  logic        taken;

  target_gen u_target_gen (
    .is_jalr_i  (is_jalr_i),
    .pc_i       (pc_i),
    .imm_i      (imm_i),
    .rs1_i      (rs1_i),
    .target_o   (target),
    .misalign_o (tgt_misalign)
  );

  assign taken  = valid_i & ((is_branch_i & branch_i) | is_jal_i | is_jalr_i);
  assign link_o = pc_i + 32'd4;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (taken && tgt_misalign) begin
          misalign_d = 1'b1;
        end else if (taken) begin
          redirect_pc_d = target;
          state_d       = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (fetch_ready_i) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Outputs are registered, so they are decoded from the next state.
    redirect_valid_d = (state_d == ST_REDIRECT);
    flush_d          = (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      redirect_pc_q    <= 32'd0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign misalign_o       = misalign_q;
  assign stall_o          = (state_q == ST_REDIRECT) & ~fetch_ready_i;

`ifdef BRANCH_STAT_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (state_q == ST_IDLE && valid_i && is_branch_i) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
      if (branch_i) taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;
`endif

endmodule
